// File: rtl/pe_pulse_acc.sv
// pe_pulse_acc: per-column pulse counter and MSB-first bit-plane accumulator with a valid/ready result stream.
// Ports:
//   clk         single clock; falling edge captures pulses, rising edge runs everything else
//   rst_n       synchronous active-low reset (sampled on both edges by their respective flops)
//   col_pulse_n per-column pulse lines, active low during the low phase of clk
//   acc_start   clear all state and begin plane 0 (wins over everything else)
//   plane_end   current plane's pulse trains are complete
//   busy        high while accumulating or streaming results
//   out_valid   result beat valid
//   out_ready   downstream accepts the beat
//   out_col     column index of the current beat
//   out_data    accumulated result of column out_col
//   acc_done    one-cycle strobe after the last beat is accepted
module pe_pulse_acc #(
  parameter int WID_Y = 8,
  parameter int COL   = 2**WID_Y,
  parameter int CNT_W = 7,
  parameter int BITS  = 8,
  parameter int ACC_W = CNT_W+BITS,
  parameter int DLY   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COL-1:0]   col_pulse_n,
  input  logic             acc_start,
  input  logic             plane_end,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WID_Y-1:0] out_col,
  output logic [ACC_W-1:0] out_data,
  output logic             acc_done
);
  localparam int PW = $clog2(BITS+1);
  typedef enum logic [1:0] {IDLE, RUN, READ} state_t;
  state_t                    state_q, state_d;
  logic [COL-1:0]            cap_q;
  logic [COL-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [COL-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [PW-1:0]             plane_q, plane_d;
  logic [WID_Y-1:0]          rd_q, rd_d;
  logic [ACC_W-1:0]          data_q, data_d;
  logic                      done_q, done_d;
  logic                      unused_dly;
  assign unused_dly = (DLY != 0);
  // Pulses are only low during the low phase, so they are caught on the falling edge.
  always_ff @(negedge clk) begin
    if (!rst_n) cap_q <= '0;
    else cap_q <= ~col_pulse_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      plane_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      plane_q <= plane_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    plane_d = plane_q;
    rd_d    = rd_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (acc_start) begin
      state_d = RUN;
      cnt_d   = '0;
      acc_d   = '0;
      plane_d = '0;
      rd_d    = '0;
      data_d  = '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < COL; i++) begin
        // The plane_end cycle's capture still belongs to the closing plane, so it is folded in directly.
        if (plane_end) begin
          acc_d[i] = (acc_q[i] << 1) + ACC_W'({1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, cap_q[i]});
          cnt_d[i] = '0;
        end else if (cap_q[i] && cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (plane_end) begin
        plane_d = plane_q + PW'(1);
        if (plane_q == PW'(BITS-1)) begin
          state_d = READ;
          rd_d    = '0;
          data_d  = acc_d[0];
        end
      end
    end else if (state_q == READ && out_ready) begin
      rd_d   = rd_q + WID_Y'(1);
      data_d = acc_q[rd_d];
      if (rd_q == WID_Y'(COL-1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        data_d  = '0;
      end
    end
  end
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == READ;
  assign out_col   = rd_q;
  assign out_data  = data_q;
  assign acc_done  = done_q;
endmodule

// File: tb/tb_pe_pulse_acc.sv
// tb_pe_pulse_acc: randomized and directed checks of pe_pulse_acc against a plane-sum reference model.
module tb_pe_pulse_acc;
  localparam int WID_Y = 8;
  localparam int COL   = 256;
  localparam int CNT_W = 7;
  localparam int BITS  = 8;
  localparam int ACC_W = 15;
  localparam int SAT   = 2**CNT_W - 1;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             acc_start = 1'b0;
  logic             plane_end = 1'b0;
  logic             out_ready = 1'b0;
  logic [COL-1:0]   col_pulse_n = '1;
  logic             busy, out_valid, acc_done;
  logic [WID_Y-1:0] out_col;
  logic [ACC_W-1:0] out_data;
  int vectors = 0;
  int errors  = 0;
  bit running = 0;
  int planes  = 0;
  int nonend[COL];
  int exp_acc[COL];
  int got[COL];
  always #5 clk = ~clk;
  pe_pulse_acc #(.WID_Y(WID_Y), .COL(COL), .CNT_W(CNT_W), .BITS(BITS), .ACC_W(ACC_W), .DLY(1)) dut (
    .clk(clk), .rst_n(rst_n), .col_pulse_n(col_pulse_n), .acc_start(acc_start), .plane_end(plane_end),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_data(out_data),
    .acc_done(acc_done)
  );
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "watchdog");
  end
  function automatic logic [COL-1:0] rnd_pv(input int dens);
    logic [COL-1:0] v;
    for (int i = 0; i < COL; i++) v[i] = ($urandom_range(99) < dens);
    return v;
  endfunction
  // One clock cycle: pulses driven here are captured in this cycle's low phase and the strobes are sampled at the next rising edge.
  task automatic step(input logic st, input logic pe, input logic [COL-1:0] pv);
    int pc;
    acc_start   = st;
    plane_end   = pe;
    col_pulse_n = ~pv;
    if (st) begin
      running = 1;
      planes  = 0;
      for (int i = 0; i < COL; i++) begin
        nonend[i]  = 0;
        exp_acc[i] = 0;
      end
    end else if (running) begin
      for (int i = 0; i < COL; i++) begin
        if (pe) begin
          pc         = (nonend[i] > SAT ? SAT : nonend[i]) + int'(pv[i]);
          exp_acc[i] = (exp_acc[i] * 2 + pc) % (2**ACC_W);
          nonend[i]  = 0;
        end else begin
          nonend[i] += int'(pv[i]);
        end
      end
      if (pe) begin
        planes++;
        if (planes == BITS) running = 0;
      end
    end
    @(posedge clk);
    #1;
    acc_start   = 1'b0;
    plane_end   = 1'b0;
    col_pulse_n = '1;
  endtask
  task automatic run_planes(input int dens, input int maxlen);
    int len;
    for (int p = 0; p < BITS; p++) begin
      len = $urandom_range(maxlen, 1);
      for (int c = 0; c < len; c++) step(1'b0, c == len - 1, rnd_pv(dens));
    end
  endtask
  task automatic run_random(input int dens, input int maxlen);
    step(1'b1, 1'b0, rnd_pv(dens));
    run_planes(dens, maxlen);
  endtask
  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready; abort_at >= 0 stops before that beat is offered.
  task automatic drain(input int mode, input int abort_at);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    while (idx < COL && cyc < 3000) begin
      if (abort_at >= 0 && idx == abort_at) return;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(1));
      out_ready = rdy;
      vectors++;
      if ({out_valid, busy, acc_done, out_col, out_data} !== {1'b1, 1'b1, 1'b0, WID_Y'(idx), ACC_W'(exp_acc[idx])}) begin
        errors++;
        $display("FAIL beat%0d: valid=%b busy=%b done=%b col=%0d data=%0d, expected valid=1 busy=1 done=0 col=%0d data=%0d",
                 idx, out_valid, busy, acc_done, out_col, out_data, idx, exp_acc[idx]);
      end
      got[idx] = int'(out_data);
      @(posedge clk);
      #1;
      if (rdy) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    vectors++;
    if (idx != COL) begin
      errors++;
      $display("FAIL drain_count: beats=%0d expected %0d", idx, COL);
    end
    vectors++;
    if ({acc_done, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL done_cycle: done/busy/valid=%b%b%b expected 100", acc_done, busy, out_valid);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (acc_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: acc_done=%b expected 0", acc_done);
    end
  endtask
  task automatic check_col(input string name, input int col, input int want);
    vectors++;
    if (got[col] !== want) begin
      errors++;
      $display("FAIL %s: col %0d data=%0d expected %0d", name, col, got[col], want);
    end
  endtask
  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({busy, out_valid, acc_done, out_col, out_data} !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b valid=%b done=%b col=%0d data=%0d expected all 0",
               name, busy, out_valid, acc_done, out_col, out_data);
    end
  endtask
  task automatic test_reset();
    rst_n     = 1'b0;
    acc_start = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    acc_start = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    running   = 0;
  endtask
  task automatic test_idle();
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'($urandom_range(1)), rnd_pv(50));
      vectors++;
      if ({busy, out_valid, acc_done} !== 3'b000) begin
        errors++;
        $display("FAIL idle%0d: busy=%b valid=%b done=%b expected 000", c, busy, out_valid, acc_done);
      end
    end
    step(1'b1, 1'b0, rnd_pv(50));
    step(1'b0, 1'b1, '0);
    for (int p = 1; p < BITS; p++) begin
      step(1'b0, 1'b0, rnd_pv(10));
      step(1'b0, 1'b1, rnd_pv(10));
    end
    drain(0, -1);
  endtask
  task automatic test_single_plane();
    logic [COL-1:0] pv;
    step(1'b1, 1'b0, '0);
    for (int p = 0; p < BITS - 1; p++) step(1'b0, 1'b1, '0);
    for (int c = 0; c < 130; c++) begin
      pv    = '0;
      pv[1] = 1'b1;
      pv[0] = (c >= 94);
      pv[5] = (c < 3);
      step(1'b0, c == 129, pv);
    end
    drain(0, -1);
    check_col("single_col0", 0, 36);
    check_col("single_col5", 5, 3);
    check_col("single_sat", 1, 128);
    check_col("single_zero", 7, 0);
  endtask
  task automatic test_msb_boundary();
    logic [COL-1:0] pv;
    step(1'b1, 1'b0, '0);
    pv = '0; pv[2] = 1'b1;
    step(1'b0, 1'b0, pv);
    step(1'b0, 1'b1, '0);
    for (int p = 1; p < 6; p++) step(1'b0, 1'b1, '0);
    pv = '0; pv[6] = 1'b1;
    step(1'b0, 1'b0, pv);
    pv = '0; pv[3] = 1'b1;
    step(1'b0, 1'b1, pv);
    pv = '0; pv[4] = 1'b1;
    step(1'b0, 1'b0, pv);
    pv = '0; pv[2] = 1'b1;
    step(1'b0, 1'b1, pv);
    drain(1, -1);
    check_col("msb_first", 2, 129);
    check_col("boundary_in_plane", 3, 2);
    check_col("before_boundary", 6, 2);
    check_col("after_boundary", 4, 1);
  endtask
  task automatic test_backpressure();
    run_random(25, 6);
    drain(1, -1);
    run_random(40, 4);
    drain(2, -1);
  endtask
  task automatic test_abort();
    run_random(20, 5);
    drain(0, 10);
    step(1'b1, 1'b0, rnd_pv(30));
    vectors++;
    if ({busy, out_valid, acc_done} !== 3'b100) begin
      errors++;
      $display("FAIL abort_read: busy=%b valid=%b done=%b expected 100", busy, out_valid, acc_done);
    end
    for (int p = 0; p < 3; p++) step(1'b0, 1'b1, rnd_pv(30));
    step(1'b1, 1'b1, rnd_pv(30));
    run_planes(30, 4);
    drain(2, -1);
  endtask
  task automatic test_reset_run();
    run_random(30, 3);
    step(1'b1, 1'b0, rnd_pv(30));
    step(1'b0, 1'b1, rnd_pv(30));
    step(1'b0, 1'b0, rnd_pv(30));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("reset_run");
    rst_n   = 1'b1;
    running = 0;
    step(1'b0, 1'b1, rnd_pv(30));
    check_idle_outputs("reset_run_idle");
    run_random(30, 3);
    drain(0, -1);
  endtask
  task automatic test_back_to_back();
    run_random(30, 1);
    drain(0, -1);
    run_random(60, 3);
    drain(2, -1);
  endtask
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_single_plane();
    test_msb_boundary();
    test_backpressure();
    test_abort();
    test_reset_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
